// File: rtl/pc_if.sv
// Request/status bundle between the fetch-stage control and the program-counter unit.
// The master drives requests; the slave (pc_unit) returns the registered PC state.
interface pc_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DW    = 3
);
  logic             enable;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             exc_valid;
  logic [DW-1:0]    exc_depth;
  logic             eret;
  logic             rewind_valid;
  logic [DW-1:0]    rewind_depth;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] epc;
  logic             in_exc;
  logic [DW-1:0]    hist_count;
  logic             err;

  modport master (
    output enable, redirect_valid, redirect_target, exc_valid, exc_depth,
           eret, rewind_valid, rewind_depth,
    input  pc, pc_seq, epc, in_exc, hist_count, err
  );

  modport slave (
    input  enable, redirect_valid, redirect_target, exc_valid, exc_depth,
           eret, rewind_valid, rewind_depth,
    output pc, pc_seq, epc, in_exc, hist_count, err
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential advance, branch redirect, exception entry/return
// with EPC capture, and a shallow history of prior PCs used to rewind after a flush.
module pc_unit #(
  parameter int unsigned     WIDTH        = 32,
  parameter int unsigned     INC          = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h8000_0180),
  parameter int unsigned     HIST_DEPTH   = 4
) (
  input logic  clock,
  input logic  reset,
  pc_if.slave  bus
);
  localparam int unsigned DW       = $clog2(HIST_DEPTH + 1);
  localparam int unsigned IW       = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam logic [DW-1:0] HIST_MAX = DW'(HIST_DEPTH);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic             r_in_exc;
  logic [DW-1:0]    r_hist_count;
  logic             r_err;
  logic [WIDTH-1:0] r_hist [HIST_DEPTH];   // r_hist[0] is the newest prior PC

  logic [DW-1:0]    w_exc_sel;
  logic [WIDTH-1:0] w_exc_pc;
  int unsigned      w_rw_depth;
  logic [DW-1:0]    w_count_inc;
  logic             w_misaligned;

  // Faulting PC: depth clamps to the oldest valid history entry; depth 0 or empty history means pc.
  always_comb begin
    w_exc_sel = (bus.exc_depth > r_hist_count) ? r_hist_count : bus.exc_depth;
    w_exc_pc  = r_pc;
    if (w_exc_sel != '0)
      w_exc_pc = r_hist[IW'(w_exc_sel - DW'(1))];
  end

  assign w_rw_depth   = 32'(bus.rewind_depth);
  assign w_count_inc  = (r_hist_count == HIST_MAX) ? HIST_MAX : r_hist_count + DW'(1);
  assign w_misaligned = bus.redirect_target[1:0] != 2'b00;

  always_ff @(posedge clock) begin
    r_err <= 1'b0;
    if (reset) begin
      r_pc         <= RESET_VECTOR;
      r_epc        <= '0;
      r_in_exc     <= 1'b0;
      r_hist_count <= '0;
    end else if (bus.exc_valid) begin
      r_pc         <= EXC_VECTOR;
      r_hist_count <= '0;
      if (!r_in_exc) begin
        r_epc    <= w_exc_pc;
        r_in_exc <= 1'b1;
      end
    end else if (bus.eret) begin
      if (r_in_exc) begin
        r_pc         <= r_epc;
        r_in_exc     <= 1'b0;
        r_hist_count <= '0;
      end else begin
        r_err <= 1'b1;
      end
    end else if (bus.rewind_valid) begin
      if (bus.rewind_depth > r_hist_count) begin
        r_err <= 1'b1;
      end else if (bus.rewind_depth != '0) begin
        r_pc         <= r_hist[IW'(bus.rewind_depth - DW'(1))];
        r_hist_count <= r_hist_count - bus.rewind_depth;
        for (int unsigned k = 0; k < HIST_DEPTH; k++) begin
          if (k + w_rw_depth < HIST_DEPTH)
            r_hist[IW'(k)] <= r_hist[IW'(k + w_rw_depth)];
        end
      end
    end else if (bus.enable) begin
      if (bus.redirect_valid && w_misaligned) begin
        r_err <= 1'b1;
      end else begin
        r_pc         <= bus.redirect_valid ? bus.redirect_target : r_pc + WIDTH'(INC);
        r_hist_count <= w_count_inc;
        r_hist[0]    <= r_pc;
        for (int unsigned k = 1; k < HIST_DEPTH; k++)
          r_hist[IW'(k)] <= r_hist[IW'(k - 1)];
      end
    end
  end

  assign bus.pc         = r_pc;
  assign bus.pc_seq     = r_pc + WIDTH'(INC);
  assign bus.epc        = r_epc;
  assign bus.in_exc     = r_in_exc;
  assign bus.hist_count = r_hist_count;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_pc_unit.sv
// Directed and random checks of pc_unit against a queue-based reference model of the PC rules.
module tb_pc_unit;
  localparam logic [31:0] EXC_VEC = 32'h8000_0180;
  localparam int          HDEPTH  = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pc_if #(.WIDTH(32), .DW(3)) bus ();

  pc_unit #(
    .WIDTH(32), .INC(4), .RESET_VECTOR(32'h0), .EXC_VECTOR(EXC_VEC), .HIST_DEPTH(HDEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: m_hist[0] is the newest prior PC, size is the valid count.
  logic [31:0] m_pc, m_epc;
  bit          m_in_exc, m_err;
  logic [31:0] m_hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_hist(input logic [31:0] v);
    m_hist.push_front(v);
    if (m_hist.size() > HDEPTH) void'(m_hist.pop_back());
  endtask

  task automatic model_step(input bit rst, input bit en, input bit rv, input logic [31:0] rt,
                            input bit ev, input int ed, input bit er, input bit rwv, input int rwd);
    m_err = 1'b0;
    if (rst) begin
      m_pc = 32'h0; m_epc = 32'h0; m_in_exc = 1'b0; m_hist.delete();
    end else if (ev) begin
      if (!m_in_exc) begin
        if (ed == 0 || m_hist.size() == 0) m_epc = m_pc;
        else m_epc = m_hist[(ed < m_hist.size() ? ed : m_hist.size()) - 1];
        m_in_exc = 1'b1;
      end
      m_pc = EXC_VEC;
      m_hist.delete();
    end else if (er) begin
      if (m_in_exc) begin
        m_pc = m_epc; m_in_exc = 1'b0; m_hist.delete();
      end else m_err = 1'b1;
    end else if (rwv) begin
      if (rwd > m_hist.size()) m_err = 1'b1;
      else if (rwd > 0) begin
        m_pc = m_hist[rwd - 1];
        repeat (rwd) void'(m_hist.pop_front());
      end
    end else if (en) begin
      if (rv && rt[1:0] != 2'b00) m_err = 1'b1;
      else begin
        push_hist(m_pc);
        m_pc = rv ? rt : m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},     bus.pc,     m_pc);
    check({tag, ".pc_seq"}, bus.pc_seq, m_pc + 32'd4);
    check({tag, ".epc"},    bus.epc,    m_epc);
    check({tag, ".in_exc"}, 32'(bus.in_exc), 32'(m_in_exc));
    check({tag, ".hcount"}, 32'(bus.hist_count), 32'(m_hist.size()));
    check({tag, ".err"},    32'(bus.err), 32'(m_err));
  endtask

  // Apply one cycle of requests, advance the model, and compare #1 after the edge.
  task automatic step(input string tag, input bit rst, input bit en, input bit rv,
                      input logic [31:0] rt, input bit ev, input int ed, input bit er,
                      input bit rwv, input int rwd);
    reset               = rst;
    bus.enable          = en;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    bus.exc_valid       = ev;
    bus.exc_depth       = 3'(ed);
    bus.eret            = er;
    bus.rewind_valid    = rwv;
    bus.rewind_depth    = 3'(rwd);
    @(posedge clock);
    model_step(rst, en, rv, rt, ev, ed, er, rwv, rwd);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);       step(tag, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0); endtask
  task automatic adv(input string tag);        step(tag, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0); endtask
  task automatic do_reset(input string tag);   step(tag, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0); endtask

  initial begin
    m_pc = '0; m_epc = '0; m_in_exc = 0; m_err = 0;

    // Reset with a competing exception request; reset must win.
    step("rst_exc", 1, 1, 0, 32'h0, 1, 0, 0, 0, 0);
    check("rst_pc", bus.pc, 32'h0);
    check("rst_in_exc", 32'(bus.in_exc), 32'h0);
    check("rst_epc", bus.epc, 32'h0);

    // Sequential advance.
    adv("adv1"); check("adv1_pc", bus.pc, 32'd4);
    adv("adv2"); check("adv2_pc", bus.pc, 32'd8);
    adv("adv3"); check("adv3_pc", bus.pc, 32'd12);
    check("adv3_hc", 32'(bus.hist_count), 32'd3);

    // Branch at pc=8, stalled redirects ignored, misaligned target rejected.
    do_reset("r2"); adv("b_a1"); adv("b_a2");
    step("br", 0, 1, 1, 32'h100, 0, 0, 0, 0, 0);  check("br_pc", bus.pc, 32'h100);
    step("stall1", 0, 0, 1, 32'h200, 0, 0, 0, 0, 0);
    step("stall2", 0, 0, 1, 32'h200, 0, 0, 0, 0, 0); check("stall_pc", bus.pc, 32'h100);
    step("mis", 0, 1, 1, 32'h102, 0, 0, 0, 0, 0);
    check("mis_pc", bus.pc, 32'h100); check("mis_err", 32'(bus.err), 32'h1);
    idle("mis_after"); check("mis_err_clr", 32'(bus.err), 32'h0);

    // History saturation and rewind.
    do_reset("r3");
    for (int i = 0; i < 6; i++) adv("h_adv");
    check("h_hc", 32'(bus.hist_count), 32'd4);
    step("rw2", 0, 1, 0, 32'h0, 0, 0, 0, 1, 2);
    check("rw2_pc", bus.pc, 32'd16); check("rw2_hc", 32'(bus.hist_count), 32'd2);
    step("rw3", 0, 1, 0, 32'h0, 0, 0, 0, 1, 3);
    check("rw3_err", 32'(bus.err), 32'h1); check("rw3_pc", bus.pc, 32'd16);
    step("rw0", 0, 0, 0, 32'h0, 0, 0, 0, 1, 0);

    // Exception with depth, nesting, return, spurious return.
    do_reset("r4");
    step("e_br", 0, 1, 1, 32'h3C, 0, 0, 0, 0, 0);
    adv("e_adv"); check("e_pc40", bus.pc, 32'h40);
    step("exc1", 0, 0, 0, 32'h0, 1, 1, 0, 0, 0);
    check("exc1_pc", bus.pc, EXC_VEC); check("exc1_epc", bus.epc, 32'h3C);
    adv("e_in");
    step("exc2", 0, 0, 0, 32'h0, 1, 0, 0, 0, 0); check("exc2_epc", bus.epc, 32'h3C);
    step("eret1", 0, 0, 0, 32'h0, 0, 0, 1, 0, 0);
    check("eret1_pc", bus.pc, 32'h3C); check("eret1_inx", 32'(bus.in_exc), 32'h0);
    step("eret2", 0, 0, 0, 32'h0, 0, 0, 1, 0, 0); check("eret2_err", 32'(bus.err), 32'h1);

    // Wrap-around and priority.
    step("w_br", 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    check("w_seq", bus.pc_seq, 32'h0);
    adv("wrap"); check("wrap_pc", bus.pc, 32'h0); check("wrap_err", 32'(bus.err), 32'h0);
    step("prio", 0, 1, 1, 32'h500, 1, 0, 1, 1, 1);
    check("prio_pc", bus.pc, EXC_VEC); check("prio_inx", 32'(bus.in_exc), 32'h1);
    step("rst_mid", 1, 0, 0, 32'h0, 1, 0, 0, 0, 0);
    check("rstm_pc", bus.pc, 32'h0); check("rstm_epc", bus.epc, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rt;
      rt = {$urandom_range(0, 255), 2'b00} + 32'hFFFF_FF00 * 32'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) rt[1:0] = 2'($urandom_range(1, 3));
      step("rnd", $urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, rt, $urandom_range(0, 14) == 0, $urandom_range(0, 7),
           $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
